// File: rtl/bitgen_sprite_layer.sv
// Multi-slot sprite renderer sharing one synchronous RGB565 sprite ROM; fixed 3-cycle latency.
// Optional SPRITE_DEBUG_BOX_EN: transparent texels inside a hit box render opaque magenta.
module bitgen_sprite_layer #(
  parameter int unsigned NUM_SPRITES   = 4,
  parameter int unsigned SPRITE_WIDTH  = 32,
  parameter int unsigned SPRITE_HEIGHT = 32,
  parameter int unsigned SCALE         = 3,
  parameter int unsigned NUM_FRAMES    = 4,
  parameter int unsigned ANIM_DIV      = 5_000_000,
  parameter int unsigned ADDR_W        = 13,
  localparam int unsigned IdW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                          pix_clk,
  input  logic                          rst,
  input  logic                          bright,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          frame_latch,
  input  logic [10*NUM_SPRITES-1:0]     spr_x,
  input  logic [10*NUM_SPRITES-1:0]     spr_y,
  input  logic [ADDR_W*NUM_SPRITES-1:0] spr_base,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_flip,
  input  logic [NUM_SPRITES-1:0]        spr_anim_en,
  output logic [ADDR_W-1:0]             sprite_addr,
  input  logic [15:0]                   sprite_data,
  output logic [7:0]                    vga_r,
  output logic [7:0]                    vga_g,
  output logic [7:0]                    vga_b,
  output logic                          pixel_opaque,
  output logic [IdW-1:0]                hit_id
);

  localparam int unsigned DivW    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned FrameSz = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam logic [10:0] BoxW    = 11'(SCALE * SPRITE_WIDTH);
  localparam logic [10:0] BoxH    = 11'(SCALE * SPRITE_HEIGHT);
  localparam logic [15:0] Transparent = 16'hF81F;

  logic [10*NUM_SPRITES-1:0]     x_q, y_q;
  logic [ADDR_W*NUM_SPRITES-1:0] base_q;
  logic [NUM_SPRITES-1:0]        en_q, flip_q, anim_q;
  logic [3:0]                    frame_q [NUM_SPRITES];
  logic [DivW-1:0]               div_q;
  logic                          tick;

  assign tick = (div_q == DivW'(ANIM_DIV - 1));

  // Shadow copies, animation divider and per-slot frame indices
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      base_q <= '0;
      en_q   <= '0;
      flip_q <= '0;
      anim_q <= '0;
      div_q  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) frame_q[i] <= '0;
    end else begin
      if (frame_latch) begin
        x_q    <= spr_x;
        y_q    <= spr_y;
        base_q <= spr_base;
        en_q   <= spr_en;
        flip_q <= spr_flip;
        anim_q <= spr_anim_en;
      end
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (anim_q[i]) frame_q[i] <= (frame_q[i] == 4'(NUM_FRAMES - 1)) ? 4'd0 : frame_q[i] + 4'd1;
        end
      end
    end
  end

  logic           hit;
  logic [IdW-1:0] win;

  // Descending scan so the lowest-index hitting slot is assigned last and wins
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (en_q[i] &&
          (hcount >= x_q[10*i +: 10]) && ({1'b0, hcount} < {1'b0, x_q[10*i +: 10]} + BoxW) &&
          (vcount >= y_q[10*i +: 10]) && ({1'b0, vcount} < {1'b0, y_q[10*i +: 10]} + BoxH)) begin
        hit = 1'b1;
        win = IdW'(i);
      end
    end
  end

  logic [9:0]        win_x, win_y;
  logic [ADDR_W-1:0] win_base;
  logic [31:0]       dx, dy, col, row, offs;
  logic [ADDR_W-1:0] addr_d;

  assign win_x    = x_q[10*win +: 10];
  assign win_y    = y_q[10*win +: 10];
  assign win_base = base_q[ADDR_W*win +: ADDR_W];

  always_comb begin
    dx  = 32'(hcount) - 32'(win_x);
    dy  = 32'(vcount) - 32'(win_y);
    col = dx / SCALE;
    if (flip_q[win]) col = SPRITE_WIDTH - 1 - col;
    row    = dy / SCALE;
    offs   = 32'(win_base) + 32'(frame_q[win]) * FrameSz + row * SPRITE_WIDTH + col;
    addr_d = (hit && bright) ? offs[ADDR_W-1:0] : base_q[ADDR_W-1:0];
  end

  logic           hit1_q, hit2_q, bright1_q, bright2_q;
  logic [IdW-1:0] id1_q, id2_q;

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      sprite_addr <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      bright1_q   <= 1'b0;
      bright2_q   <= 1'b0;
      id1_q       <= '0;
      id2_q       <= '0;
    end else begin
      sprite_addr <= addr_d;
      hit1_q      <= hit;
      bright1_q   <= bright;
      id1_q       <= win;
      hit2_q      <= hit1_q;
      bright2_q   <= bright1_q;
      id2_q       <= id1_q;
    end
  end

  logic [7:0]     r_d, g_d, b_d;
  logic           op_d;
  logic [IdW-1:0] id_d;

  always_comb begin
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    op_d = 1'b0;
    id_d = '0;
    if (bright2_q) begin
      {r_d, g_d, b_d} = 24'h88CC88;
      if (hit2_q) begin
        id_d = id2_q;
        if (sprite_data != Transparent) begin
          r_d  = {sprite_data[15:11], sprite_data[15:13]};
          g_d  = {sprite_data[10:5], sprite_data[10:9]};
          b_d  = {sprite_data[4:0], sprite_data[4:2]};
          op_d = 1'b1;
        end
`ifdef SPRITE_DEBUG_BOX_EN
        else begin
          {r_d, g_d, b_d} = 24'hFF00FF;
          op_d            = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vga_r        <= '0;
      vga_g        <= '0;
      vga_b        <= '0;
      pixel_opaque <= 1'b0;
      hit_id       <= '0;
    end else begin
      vga_r        <= r_d;
      vga_g        <= g_d;
      vga_b        <= b_d;
      pixel_opaque <= op_d;
      hit_id       <= id_d;
    end
  end

endmodule

// File: tb/tb_bitgen_sprite_layer.sv
// Randomised bench for bitgen_sprite_layer against a per-pixel reference model and a ROM model.
module tb_bitgen_sprite_layer;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int SC = 3;
  localparam int NF = 4;
  localparam int AD = 4;
  localparam int AW = 13;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       op;
    logic [1:0] id;
  } pix_t;

  logic            pix_clk = 1'b0;
  logic            rst, bright, frame_latch;
  logic [9:0]      hcount, vcount;
  logic [10*NS-1:0] spr_x, spr_y;
  logic [AW*NS-1:0] spr_base;
  logic [NS-1:0]   spr_en, spr_flip, spr_anim_en;
  logic [AW-1:0]   sprite_addr;
  logic [15:0]     sprite_data = 16'h0;
  logic [7:0]      vga_r, vga_g, vga_b;
  logic            pixel_opaque;
  logic [1:0]      hit_id;

  bitgen_sprite_layer #(
    .NUM_SPRITES(NS), .SPRITE_WIDTH(W), .SPRITE_HEIGHT(H), .SCALE(SC),
    .NUM_FRAMES(NF), .ANIM_DIV(AD), .ADDR_W(AW)
  ) dut (
    .pix_clk(pix_clk), .rst(rst), .bright(bright), .hcount(hcount), .vcount(vcount),
    .frame_latch(frame_latch), .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
    .spr_en(spr_en), .spr_flip(spr_flip), .spr_anim_en(spr_anim_en),
    .sprite_addr(sprite_addr), .sprite_data(sprite_data), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .pixel_opaque(pixel_opaque), .hit_id(hit_id)
  );

  always #5 pix_clk = ~pix_clk;

  logic [15:0] rom [1 << AW];
  always @(posedge pix_clk) sprite_data <= rom[sprite_addr];

  // Reference model state
  int   sx [NS], sy [NS], sbase [NS], frm [NS];
  bit   sen [NS], sflip [NS], sanim [NS];
  int   divc;
  pix_t exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      sx[i] = 0; sy[i] = 0; sbase[i] = 0; frm[i] = 0;
      sen[i] = 0; sflip[i] = 0; sanim[i] = 0;
    end
    divc = 0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  function automatic void model_pixel(output int addr, output pix_t px);
    int h, v, w, col, row, d;
    h = int'(hcount);
    v = int'(vcount);
    w = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (sen[i] && h >= sx[i] && h < sx[i] + SC * W && v >= sy[i] && v < sy[i] + SC * H) w = i;
    px = '0;
    addr = sbase[0];
    if (!bright) return;
    if (w < 0) begin
      px.r = 8'h88; px.g = 8'hCC; px.b = 8'h88;
      return;
    end
    col = (h - sx[w]) / SC;
    if (sflip[w]) col = W - 1 - col;
    row = (v - sy[w]) / SC;
    addr = (sbase[w] + frm[w] * W * H + row * W + col) % (1 << AW);
    d = int'(rom[addr]);
    px.id = 2'(w);
    if (d == 'hF81F) begin
`ifdef SPRITE_DEBUG_BOX_EN
      px.r = 8'hFF; px.g = 8'h00; px.b = 8'hFF; px.op = 1'b1;
`else
      px.r = 8'h88; px.g = 8'hCC; px.b = 8'h88;
`endif
    end else begin
      px.r  = 8'((d / 2048) * 8 + (d / 2048) / 4);
      px.g  = 8'(((d / 32) % 64) * 4 + ((d / 32) % 64) / 16);
      px.b  = 8'((d % 32) * 8 + (d % 32) / 4);
      px.op = 1'b1;
    end
  endfunction

  // One pixel clock: predict, clock, advance model, then compare address and delayed pixel
  task automatic step();
    int   a;
    pix_t p, q;
    model_pixel(a, p);
    @(posedge pix_clk);
    if (divc == AD - 1) begin
      divc = 0;
      for (int i = 0; i < NS; i++) if (sanim[i]) frm[i] = (frm[i] + 1) % NF;
    end else begin
      divc++;
    end
    if (frame_latch) begin
      for (int i = 0; i < NS; i++) begin
        sx[i]    = int'(spr_x[10*i +: 10]);
        sy[i]    = int'(spr_y[10*i +: 10]);
        sbase[i] = int'(spr_base[AW*i +: AW]);
        sen[i]   = spr_en[i];
        sflip[i] = spr_flip[i];
        sanim[i] = spr_anim_en[i];
      end
    end
    exp_q.push_back(p);
    #1;
    q = exp_q.pop_front();
    check_eq("addr", 32'(sprite_addr), 32'(a));
    check_eq("vga_r", 32'(vga_r), 32'(q.r));
    check_eq("vga_g", 32'(vga_g), 32'(q.g));
    check_eq("vga_b", 32'(vga_b), 32'(q.b));
    check_eq("opaque", 32'(pixel_opaque), 32'(q.op));
    check_eq("hit_id", 32'(hit_id), 32'(q.id));
  endtask

  task automatic set_slot(input int i, input int x, input int y, input int base, input bit en,
                          input bit flip, input bit anim);
    spr_x[10*i +: 10]    = 10'(x);
    spr_y[10*i +: 10]    = 10'(y);
    spr_base[AW*i +: AW] = AW'(base);
    spr_en[i]            = en;
    spr_flip[i]          = flip;
    spr_anim_en[i]       = anim;
  endtask

  task automatic latch();
    frame_latch = 1'b1;
    step();
    frame_latch = 1'b0;
  endtask

  task automatic at(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    bright = 1'b1;
    step();
  endtask

  initial begin
    int   seen, a0, j;
    logic [31:0] rnd;

    for (int i = 0; i < (1 << AW); i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? 16'hF81F : 16'($urandom);
    rom[1]    = 16'hF81F;
    rom[4096] = 16'hFFFF;

    rst = 1'b1; bright = 1'b0; frame_latch = 1'b0; hcount = '0; vcount = '0;
    spr_x = '0; spr_y = '0; spr_base = '0; spr_en = '0; spr_flip = '0; spr_anim_en = '0;
    #23;
    check_eq("rst_addr", 32'(sprite_addr), 32'd0);
    check_eq("rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'd0);
    check_eq("rst_op", 32'(pixel_opaque), 32'd0);
    rst = 1'b0;
    model_reset();

    // Single slot fetch, flip, priority
    set_slot(0, 100, 50, 0, 1, 0, 0);
    latch();
    at(100, 50); check_eq("tp_addr_origin", 32'(sprite_addr), 32'd0);
    at(103, 50); check_eq("tp_addr_col1", 32'(sprite_addr), 32'd1);
    at(100, 53); check_eq("tp_addr_row1", 32'(sprite_addr), 32'd32);
    set_slot(0, 100, 50, 0, 1, 1, 0);
    latch();
    at(100, 50); check_eq("tp_addr_flip", 32'(sprite_addr), 32'd31);
    set_slot(0, 100, 50, 0, 1, 0, 0);
    set_slot(1, 100, 50, 4096, 1, 0, 0);
    latch();
    at(100, 50); check_eq("tp_prio_addr", 32'(sprite_addr), 32'd0);
    at(100, 50); at(100, 50); check_eq("tp_prio_id0", 32'(hit_id), 32'd0);
    set_slot(0, 100, 50, 0, 0, 0, 0);
    latch();
    at(100, 50); check_eq("tp_prio_addr1", 32'(sprite_addr), 32'd4096);
    at(100, 50); at(100, 50);
    check_eq("tp_prio_id1", 32'(hit_id), 32'd1);
    check_eq("tp_white", {8'h0, vga_r, vga_g, vga_b}, 32'hFFFFFF);
    check_eq("tp_white_op", 32'(pixel_opaque), 32'd1);

    // Transparent texel at slot 0 address 1
    set_slot(0, 100, 50, 0, 1, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0, 0);
    latch();
    at(103, 50); at(103, 50); at(103, 50);
`ifdef SPRITE_DEBUG_BOX_EN
    check_eq("tp_transp_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'hFF00FF);
    check_eq("tp_transp_op", 32'(pixel_opaque), 32'd1);
`else
    check_eq("tp_transp_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h88CC88);
    check_eq("tp_transp_op", 32'(pixel_opaque), 32'd0);
`endif

    // Animation: all four frames appear, then hold when disabled
    set_slot(0, 100, 50, 0, 1, 0, 1);
    latch();
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      at(100, 50);
      seen |= 1 << (int'(sprite_addr) / 1024);
    end
    check_eq("tp_anim_frames", 32'(seen), 32'hF);
    set_slot(0, 100, 50, 0, 1, 0, 0);
    latch();
    at(100, 50);
    a0 = int'(sprite_addr);
    for (int i = 0; i < 8; i++) begin
      at(100, 50);
      check_eq("tp_anim_hold", 32'(sprite_addr), 32'(a0));
    end

    // Tear-free: unlatched move has no effect, latched move applies next edge
    set_slot(0, 400, 50, 0, 1, 0, 0);
    at(100, 50); at(100, 50);
    latch();
    at(400, 50); at(400, 50); at(400, 50);
    check_eq("tp_moved_op", 32'(pixel_opaque), 32'(rom[int'(sprite_addr)] != 16'hF81F));

    // Asynchronous reset mid-sprite
    #3 rst = 1'b1;
    #1;
    check_eq("mid_rst_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'd0);
    check_eq("mid_rst_op", 32'(pixel_opaque), 32'd0);
    check_eq("mid_rst_id", 32'(hit_id), 32'd0);
    check_eq("mid_rst_addr", 32'(sprite_addr), 32'd0);
    @(posedge pix_clk); @(posedge pix_clk);
    #3 rst = 1'b0;
    model_reset();
    at(400, 50); at(400, 50); at(400, 50);
    latch();

    // Randomised traffic, including boxes that extend past column/row 1023
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < NS; i++) begin
          rnd = $urandom;
          set_slot(i, (rnd[0]) ? $urandom_range(0, 1023) : $urandom_range(0, 300),
                   (rnd[1]) ? $urandom_range(0, 1023) : $urandom_range(0, 300),
                   $urandom_range(0, (1 << AW) - 1), rnd[2] | rnd[3], rnd[4], rnd[5]);
        end
      end
      frame_latch = ($urandom_range(0, 19) == 0);
      bright      = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 1) begin
        j      = $urandom_range(0, NS - 1);
        hcount = 10'(int'(spr_x[10*j +: 10]) + $urandom_range(0, 99) - 2);
        vcount = 10'(int'(spr_y[10*j +: 10]) + $urandom_range(0, 99) - 2);
      end else begin
        hcount = 10'($urandom_range(0, 1023));
        vcount = 10'($urandom_range(0, 1023));
      end
      step();
    end
    frame_latch = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
